// File: rtl/hash_req_arbiter.sv
// Round-robin arbiter sharing one hash engine between two requesters.
// Issued source IDs are queued so in-order returns route back to their owner.
module hash_req_arbiter #(
  parameter int CMD_W     = 128,
  parameter int RET_W     = 96,
  parameter int MAX_OUTST = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   req_cmd_valid,
  input  logic [2*CMD_W-1:0]           req_cmd_data,
  output logic [1:0]                   req_cmd_ready,
  output logic                         hash_cmd_valid,
  output logic [CMD_W-1:0]             hash_cmd_data,
  input  logic                         hash_cmd_ready,
  input  logic                         hash_ret_valid,
  input  logic [RET_W-1:0]             hash_ret_data,
  output logic                         hash_ret_ready,
  output logic [1:0]                   req_ret_valid,
  output logic [RET_W-1:0]             req_ret_data,
  input  logic [1:0]                   req_ret_ready,
  output logic [$clog2(MAX_OUTST):0]   outstanding,
  output logic                         err_unexp_ret
);

  localparam int PW = $clog2(MAX_OUTST);

  logic             r_cmd_valid;
  logic [CMD_W-1:0] r_cmd_data;
  logic             r_cmd_src;
  logic             r_rr_ptr;
  logic             r_fifo [MAX_OUTST];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic [PW:0]      r_outst;
  logic             r_err;

  logic [1:0]       w_grant;
  logic             w_can_load;
  logic             w_admit;
  logic [PW+1:0]    w_pending;
  logic             w_load;
  logic [CMD_W-1:0] w_sel_data;
  logic             w_issue;
  logic             w_empty;
  logic             w_head;
  logic             w_pop;
  logic             w_unexp;

  // Grant: pointer names the preferred requester; the other wins only if it is idle.
  always_comb begin
    w_grant = '0;
    if (r_rr_ptr) begin
      if (req_cmd_valid[1])      w_grant = 2'b10;
      else if (req_cmd_valid[0]) w_grant = 2'b01;
    end else begin
      if (req_cmd_valid[0])      w_grant = 2'b01;
      else if (req_cmd_valid[1]) w_grant = 2'b10;
    end
  end

  assign w_issue    = r_cmd_valid && hash_cmd_ready;
  assign w_can_load = !r_cmd_valid || hash_cmd_ready;
  assign w_pending  = {1'b0, r_outst} + (PW+2)'(r_cmd_valid);
  assign w_admit    = w_pending < (PW+2)'(MAX_OUTST);
  assign w_sel_data = w_grant[1] ? req_cmd_data[2*CMD_W-1:CMD_W] : req_cmd_data[CMD_W-1:0];

  always_comb begin
    req_cmd_ready = '0;
    if (!reset && w_can_load && w_admit) req_cmd_ready = w_grant;
  end

  assign w_load = |req_cmd_ready;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_head  = r_fifo[r_rd_ptr[PW-1:0]];

  // With nothing outstanding a return is accepted and dropped so the engine never stalls.
  always_comb begin
    req_ret_valid  = '0;
    hash_ret_ready = 1'b0;
    if (!reset) begin
      if (w_empty) begin
        hash_ret_ready = hash_ret_valid;
      end else begin
        hash_ret_ready         = req_ret_ready[w_head];
        req_ret_valid[w_head]  = hash_ret_valid;
      end
    end
  end

  assign w_pop   = hash_ret_valid && hash_ret_ready && !w_empty;
  assign w_unexp = hash_ret_valid && w_empty && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_valid <= 1'b0;
      r_cmd_data  <= '0;
      r_cmd_src   <= 1'b0;
      r_rr_ptr    <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_outst     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_load) begin
        r_cmd_valid <= 1'b1;
        r_cmd_data  <= w_sel_data;
        r_cmd_src   <= w_grant[1];
        r_rr_ptr    <= w_grant[0];
      end else if (w_issue) begin
        r_cmd_valid <= 1'b0;
      end
      if (w_issue) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
      case ({w_issue, w_pop})
        2'b10:   r_outst <= r_outst + (PW+1)'(1);
        2'b01:   r_outst <= r_outst - (PW+1)'(1);
        default: r_outst <= r_outst;
      endcase
      if (w_unexp) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) r_fifo[r_wr_ptr[PW-1:0]] <= r_cmd_src;
  end

  assign hash_cmd_valid = r_cmd_valid;
  assign hash_cmd_data  = r_cmd_data;
  assign req_ret_data   = hash_ret_data;
  assign outstanding    = r_outst;
  assign err_unexp_ret  = r_err;

endmodule

// File: tb/tb_hash_req_arbiter.sv
// Directed bench for hash_req_arbiter: arbitration order, credit limit,
// in-order return routing, stalls, unexpected returns and reset.
module tb_hash_req_arbiter;

  localparam int CMD_W = 128;
  localparam int RET_W = 96;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         req_cmd_valid;
  logic [2*CMD_W-1:0] req_cmd_data;
  logic [1:0]         req_cmd_ready;
  logic               hash_cmd_valid;
  logic [CMD_W-1:0]   hash_cmd_data;
  logic               hash_cmd_ready;
  logic               hash_ret_valid;
  logic [RET_W-1:0]   hash_ret_data;
  logic               hash_ret_ready;
  logic [1:0]         req_ret_valid;
  logic [RET_W-1:0]   req_ret_data;
  logic [1:0]         req_ret_ready;
  logic [2:0]         outstanding;
  logic               err_unexp_ret;

  logic               echo_en;
  int unsigned        n_vec  = 0;
  int unsigned        n_miss = 0;

  localparam logic [CMD_W-1:0] PAY0 = 128'hA5A5_0000_1234_0000_0000_0000_0000_00A0;
  localparam logic [CMD_W-1:0] PAY1 = 128'h5A5A_0000_5678_0000_0000_0000_0000_00B1;

  always #5 clk = ~clk;

  hash_req_arbiter #(
    .CMD_W(CMD_W),
    .RET_W(RET_W),
    .MAX_OUTST(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_cmd_valid(req_cmd_valid),
    .req_cmd_data(req_cmd_data),
    .req_cmd_ready(req_cmd_ready),
    .hash_cmd_valid(hash_cmd_valid),
    .hash_cmd_data(hash_cmd_data),
    .hash_cmd_ready(hash_cmd_ready),
    .hash_ret_valid(hash_ret_valid),
    .hash_ret_data(hash_ret_data),
    .hash_ret_ready(hash_ret_ready),
    .req_ret_valid(req_ret_valid),
    .req_ret_data(req_ret_data),
    .req_ret_ready(req_ret_ready),
    .outstanding(outstanding),
    .err_unexp_ret(err_unexp_ret)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; when echo_en is set, the engine returns last cycle's issue.
  task automatic step();
    logic       iss;
    logic [95:0] d;
    iss = hash_cmd_valid && hash_cmd_ready;
    d   = hash_cmd_data[95:0];
    @(posedge clk);
    #1;
    if (echo_en) begin
      hash_ret_valid = iss;
      hash_ret_data  = d;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    req_cmd_valid  = '0;
    req_cmd_data   = '0;
    hash_cmd_ready = 1'b0;
    hash_ret_valid = 1'b0;
    hash_ret_data  = '0;
    req_ret_ready  = '0;
    echo_en        = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state, with requests pending during reset
    do_reset();
    reset         = 1'b1;
    req_cmd_valid = 2'b11;
    hash_ret_valid = 1'b1;
    #1;
    chk("rst_cmd_ready", 128'(req_cmd_ready), 128'(2'b00));
    chk("rst_ret_ready", 128'(hash_ret_ready), 128'(1'b0));
    step();
    chk("rst_cmd_valid", 128'(hash_cmd_valid), 128'(1'b0));
    chk("rst_cmd_data", hash_cmd_data, 128'h0);
    chk("rst_outst", 128'(outstanding), 128'(3'd0));
    chk("rst_err", 128'(err_unexp_ret), 128'(1'b0));

    // Both requesters active, immediate echo: alternating 0,1,0,1
    do_reset();
    echo_en        = 1'b1;
    hash_cmd_ready = 1'b1;
    req_ret_ready  = 2'b11;
    req_cmd_valid  = 2'b11;
    req_cmd_data   = {PAY1, PAY0};
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_ready", 128'(req_cmd_ready), (i % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
      chk("rr_outst", 128'(outstanding), (i < 2) ? 128'd0 : 128'd1);
      if (i >= 1) chk("rr_cmd_data", hash_cmd_data, (i % 2 == 1) ? PAY0 : PAY1);
      if (i >= 2) begin
        chk("rr_ret_valid", 128'(req_ret_valid), (i % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
        chk("rr_ret_data", 128'(req_ret_data), (i % 2 == 0) ? 128'(PAY0[95:0]) : 128'(PAY1[95:0]));
      end
      step();
    end

    // Requester 1 alone, payloads 1..8, full throughput
    do_reset();
    echo_en        = 1'b1;
    hash_cmd_ready = 1'b1;
    req_ret_ready  = 2'b11;
    for (int c = 0; c < 11; c++) begin
      req_cmd_valid = (c < 8) ? 2'b10 : 2'b00;
      req_cmd_data  = {128'(c + 1), PAY0};
      #1;
      chk("solo_ready", 128'(req_cmd_ready), (c < 8) ? 128'(2'b10) : 128'(2'b00));
      if (c >= 1 && c <= 8) begin
        chk("solo_cmd_valid", 128'(hash_cmd_valid), 128'(1'b1));
        chk("solo_cmd_data", hash_cmd_data, 128'(c));
      end
      if (c >= 2 && c <= 9) begin
        chk("solo_ret_valid", 128'(req_ret_valid), 128'(2'b10));
        chk("solo_ret_data", 128'(req_ret_data), 128'(c - 1));
      end
      if (c == 9) begin
        chk("solo_cmd_idle", 128'(hash_cmd_valid), 128'(1'b0));
        chk("solo_outst9", 128'(outstanding), 128'd1);
      end
      if (c == 10) chk("solo_outst10", 128'(outstanding), 128'd0);
      step();
    end

    // Credit limit: no returns, only 4 commands issue
    do_reset();
    hash_cmd_ready = 1'b1;
    req_ret_ready  = 2'b11;
    req_cmd_valid  = 2'b01;
    req_cmd_data   = {PAY1, PAY0};
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("lim_ready", 128'(req_cmd_ready), (c < 4) ? 128'(2'b01) : 128'(2'b00));
      chk("lim_outst", 128'(outstanding), (c < 2) ? 128'd0 : 128'(c - 1));
      step();
    end
    chk("lim_cmd_idle", 128'(hash_cmd_valid), 128'(1'b0));
    hash_ret_valid = 1'b1;
    hash_ret_data  = PAY0[95:0];
    #1;
    chk("lim_ret_ready", 128'(hash_ret_ready), 128'(1'b1));
    chk("lim_ret_valid", 128'(req_ret_valid), 128'(2'b01));
    chk("lim_no_credit", 128'(req_cmd_ready), 128'(2'b00));
    step();
    hash_ret_valid = 1'b0;
    #1;
    chk("lim_outst3", 128'(outstanding), 128'd3);
    chk("lim_one_admit", 128'(req_cmd_ready), 128'(2'b01));
    step();
    #1;
    chk("lim_closed", 128'(req_cmd_ready), 128'(2'b00));
    step();
    #1;
    chk("lim_outst4", 128'(outstanding), 128'd4);
    chk("lim_closed2", 128'(req_cmd_ready), 128'(2'b00));

    // Head-of-line blocking on the return path
    do_reset();
    hash_cmd_ready = 1'b1;
    req_cmd_valid  = 2'b11;
    req_cmd_data   = {PAY1, PAY0};
    step();
    step();
    req_cmd_valid = 2'b00;
    step();
    #1;
    chk("hol_outst", 128'(outstanding), 128'd2);
    hash_ret_valid = 1'b1;
    hash_ret_data  = PAY0[95:0];
    req_ret_ready  = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("hol_valid", 128'(req_ret_valid), 128'(2'b01));
      chk("hol_ready", 128'(hash_ret_ready), 128'(1'b0));
      chk("hol_data", 128'(req_ret_data), 128'(PAY0[95:0]));
      step();
    end
    req_ret_ready = 2'b11;
    #1;
    chk("hol_a_ready", 128'(hash_ret_ready), 128'(1'b1));
    step();
    hash_ret_data = PAY1[95:0];
    #1;
    chk("hol_b_valid", 128'(req_ret_valid), 128'(2'b10));
    chk("hol_b_data", 128'(req_ret_data), 128'(PAY1[95:0]));
    step();
    hash_ret_valid = 1'b0;
    #1;
    chk("hol_drained", 128'(outstanding), 128'd0);

    // Engine back-pressure: register holds, pointer does not move
    do_reset();
    req_cmd_valid = 2'b11;
    req_cmd_data  = {PAY1, PAY0};
    #1;
    chk("stall_first", 128'(req_cmd_ready), 128'(2'b01));
    step();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_ready", 128'(req_cmd_ready), 128'(2'b00));
      chk("stall_valid", 128'(hash_cmd_valid), 128'(1'b1));
      chk("stall_data", hash_cmd_data, PAY0);
      step();
    end
    hash_cmd_ready = 1'b1;
    #1;
    chk("stall_next_rr", 128'(req_cmd_ready), 128'(2'b10));

    // Unexpected return sets sticky error
    do_reset();
    hash_ret_valid = 1'b1;
    hash_ret_data  = 96'hDEAD;
    #1;
    chk("unexp_ready", 128'(hash_ret_ready), 128'(1'b1));
    chk("unexp_no_valid", 128'(req_ret_valid), 128'(2'b00));
    step();
    hash_ret_valid = 1'b0;
    step();
    step();
    chk("unexp_err_sticky", 128'(err_unexp_ret), 128'(1'b1));

    // Reset while 3 commands are outstanding
    hash_cmd_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req_cmd_valid = 2'b01;
      req_cmd_data  = {PAY1, 128'(c + 5)};
      #1;
      chk("mid_ready", 128'(req_cmd_ready), 128'(2'b01));
      step();
    end
    req_cmd_valid = 2'b00;
    step();
    chk("mid_outst", 128'(outstanding), 128'd3);
    chk("mid_err", 128'(err_unexp_ret), 128'(1'b1));
    reset          = 1'b1;
    req_cmd_valid  = 2'b11;
    hash_ret_valid = 1'b1;
    req_ret_ready  = 2'b11;
    #1;
    chk("mid_rst_cmd_ready", 128'(req_cmd_ready), 128'(2'b00));
    chk("mid_rst_ret_valid", 128'(req_ret_valid), 128'(2'b00));
    step();
    chk("mid_rst_outst", 128'(outstanding), 128'd0);
    chk("mid_rst_err", 128'(err_unexp_ret), 128'(1'b0));
    chk("mid_rst_cmd_valid", 128'(hash_cmd_valid), 128'(1'b0));
    chk("mid_rst_cmd_data", hash_cmd_data, 128'h0);
    chk("mid_rst_ret_ready", 128'(hash_ret_ready), 128'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hash_req_arbiter.md
Name: hash_req_arbiter

Overview:
- Shares the single hash engine between two requesters: requester 0 is tcp_reassembly lookup/insert; requester 1 is the flow-aging/timeout scanner.
- Arbitrates command transfers round-robin and issues one registered command stream to the hash engine.
- Records the requester ID of each issued command in an order FIFO. Hash returns arrive in issue order, so each return is routed back to the requester named at the FIFO head.
- Sits between the requesters' hash command/return channels and the hash engine.

Parameters:
- CMD_W, 128, width of a hash command payload.
- RET_W, 96, width of a hash return payload.
- MAX_OUTST, 4, maximum number of issued commands still awaiting return; order FIFO depth, power of 2, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_cmd_valid  in  2  per-requester command valid; bit i belongs to requester i
- req_cmd_data  in  2*CMD_W  per-requester command payload; slice i belongs to requester i
- req_cmd_ready  out  2  per-requester command accepted
- hash_cmd_valid  out  1  command valid toward the hash engine
- hash_cmd_data  out  CMD_W  command payload toward the hash engine
- hash_cmd_ready  in  1  hash engine accepts the command
- hash_ret_valid  in  1  return valid from the hash engine
- hash_ret_data  in  RET_W  return payload from the hash engine
- hash_ret_ready  out  1  return accepted
- req_ret_valid  out  2  per-requester return valid
- req_ret_data  out  RET_W  return payload, shared by both requesters and qualified by req_ret_valid
- req_ret_ready  in  2  per-requester return ready
- outstanding  out  $clog2(MAX_OUTST)+1  number of commands issued and not yet returned
- err_unexp_ret  out  1  sticky flag: a return arrived while nothing was outstanding

Behaviour:
- Transfer on any channel = valid && ready on the same rising edge. A valid output, once asserted, holds valid and data stable until the transfer.
- Reset (synchronous, active-high; same behaviour if asserted mid-operation): hash_cmd_valid=0, hash_cmd_data=0, req_cmd_ready=0, hash_ret_ready=0, req_ret_valid=0, outstanding=0, err_unexp_ret=0, order FIFO emptied, round-robin pointer=0 (requester 0 has priority). Any in-flight command or return is discarded.
- Command stage: a single output register (hash_cmd_valid/hash_cmd_data plus a src ID bit).
  - The register can load when it is empty, or when it is draining this cycle (hash_cmd_ready=1).
  - Admission rule: a new command is admitted only if outstanding + (register full ? 1 : 0) < MAX_OUTST.
  - The grant is combinational from req_cmd_valid and the round-robin pointer. req_cmd_ready[i] = can-load && admission && grant[i]. At most one bit of req_cmd_ready is high.
  - Round robin: after a granted transfer from requester i, the pointer moves to 1-i. With a single requester active, that requester is served every cycle (full throughput).
  - Latency: request transfer at cycle N gives hash_cmd_valid=1 at N+1.
- Issue: on a hash_cmd transfer, the src ID is pushed into the order FIFO and outstanding increments.
- Return routing: head = order FIFO head.
  - req_ret_valid[head] = hash_ret_valid && !empty; the other bit is 0.
  - req_ret_data = hash_ret_data, passed combinationally.
  - hash_ret_ready = !empty && req_ret_ready[head].
  - A return transfer pops the FIFO and decrements outstanding.
  - A return blocked by one requester's ready stalls all later returns (in-order requirement).
- Unexpected return: hash_ret_valid while the FIFO is empty gives hash_ret_ready=1. The data is dropped, err_unexp_ret is set, and it is cleared only by reset.
- Simultaneous issue and return in one cycle: push and pop both occur and outstanding is unchanged. The admission check uses the registered count; it does not take credit for a return in the same cycle.
- FIFO: pointers wrap modulo MAX_OUTST with an extra wrap bit for full/empty. Full is never exceeded because of the admission rule.

Test Plan:
- Both requesters hold valid constantly, hash_cmd_ready=1, returns echo immediately -> issued src order is 0,1,0,1,...; each requester sees only its own returns, in order; outstanding stays at 1 or 2.
- Only requester 1 is valid for 8 commands with payloads 0x1..0x8 -> 8 consecutive hash_cmd transfers; req_cmd_ready[0] stays 0; returns are routed to req_ret_valid[1].
- No returns, hash_cmd_ready=1, MAX_OUTST=4 -> exactly 4 commands issued, then req_cmd_ready=0 and outstanding=4. A single return -> exactly one new command admitted the following cycle.
- Issue cmds A(req0) and B(req1); hold req_ret_ready[0]=0 for 5 cycles -> return A stays visible on req_ret_valid[0], hash_ret_ready=0, return B is not delivered. Release -> A is delivered, then B to requester 1.
- hash_cmd_ready=0 for 3 cycles with both requesters valid -> hash_cmd_data stays stable, no further req_cmd_ready, no pointer advance.
- Pulse hash_ret_valid with nothing outstanding -> hash_ret_ready=1, no req_ret_valid, err_unexp_ret=1 until reset. Assert reset with 3 commands outstanding -> all outputs return to reset values next cycle and outstanding=0.
